controlador_entrada_saida: RTL and testbench

Parametrised I/O controller for the single-cycle core. It replaces the fixed switch/display path with a debounced, handshaked IN instruction and N latched OUT channels. It sits between the board pins (switches, button) and the core's control signals (In, Out, Halt), and gates core progress through `HabilitaCPU`.

---
 rtl/controlador_entrada_saida.sv | 170 +++++++++++++++++
 tb/tb_controlador_entrada_saida.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/controlador_entrada_saida.sv
// I/O controller for the single-cycle core: debounced button handshake for IN,
// latched output channels for OUT, and HALT parking, all gating HabilitaCPU.
module controlador_entrada_saida #(
  parameter int LARGURA_DADO    = 32,
  parameter int LARGURA_SW      = 14,
  parameter int NUM_CANAIS      = 4,
  parameter int CICLOS_DEBOUNCE = 16,
  localparam int LARGURA_CANAL  = (NUM_CANAIS > 1) ? $clog2(NUM_CANAIS) : 1
) (
  input  logic                               Clock,
  input  logic                               Reset,
  input  logic [LARGURA_SW-1:0]              Sw,
  input  logic                               Botao,
  input  logic                               In,
  input  logic                               Out,
  input  logic                               Halt,
  input  logic [LARGURA_CANAL-1:0]           Canal,
  input  logic [LARGURA_DADO-1:0]            DadoSaida,
  output logic [LARGURA_DADO-1:0]            DadoEntrada,
  output logic                               HabilitaCPU,
  output logic [NUM_CANAIS*LARGURA_DADO-1:0] SaidaCanais,
  output logic [NUM_CANAIS-1:0]              CanalAtualizado,
  output logic                               Esperando,
  output logic                               Parado
);

  localparam int LARGURA_CONT = $clog2(CICLOS_DEBOUNCE + 1);
  localparam logic [LARGURA_CONT-1:0] LIMITE_CONT = LARGURA_CONT'(CICLOS_DEBOUNCE - 1);
  localparam logic [LARGURA_CONT-1:0] UM_CONT     = LARGURA_CONT'(1);

  typedef enum logic [1:0] {
    EXEC   = 2'd0,
    ESPERA = 2'd1,
    LIBERA = 2'd2,
    PARADO = 2'd3
  } estado_t;

  logic [1:0]              sync_r;
  logic                    btDb_r;
  logic [LARGURA_CONT-1:0] contDb_r;
  logic                    eventoPress_r;

  estado_t                 estado_r;
  estado_t                 proxEstado_s;
  logic                    habilita_s;
  logic                    escrita_s;
  logic                    canalValido_s;

  logic [LARGURA_DADO-1:0] dadoEntrada_r;
  logic                    esperando_r;
  logic                    parado_r;
  logic [LARGURA_DADO-1:0] canais_r [NUM_CANAIS];
  logic [NUM_CANAIS-1:0]   atualizado_r;

  // Synchroniser, debounce counter and press-event pulse
  always_ff @(posedge Clock) begin
    if (Reset) begin
      sync_r        <= 2'b00;
      btDb_r        <= 1'b0;
      contDb_r      <= '0;
      eventoPress_r <= 1'b0;
    end else begin
      sync_r        <= {sync_r[0], ~Botao};
      eventoPress_r <= 1'b0;
      if (sync_r[1] != btDb_r) begin
        // Flip on the N-th consecutive disagreeing cycle; the reset to zero keeps it from wrapping
        if (contDb_r >= LIMITE_CONT) begin
          btDb_r        <= sync_r[1];
          contDb_r      <= '0;
          eventoPress_r <= sync_r[1];
        end else begin
          contDb_r <= contDb_r + UM_CONT;
        end
      end else begin
        contDb_r <= '0;
      end
    end
  end

  // Handshake state register
  always_ff @(posedge Clock) begin
    if (Reset) begin
      estado_r <= EXEC;
    end else begin
      estado_r <= proxEstado_s;
    end
  end

  // Next-state and core enable decode
  always_comb begin
    proxEstado_s = estado_r;
    habilita_s   = 1'b0;
    case (estado_r)
      EXEC: begin
        habilita_s = ~In & ~Halt;
        if (Halt) begin
          proxEstado_s = PARADO;
        end else if (In) begin
          proxEstado_s = ESPERA;
        end else begin
          proxEstado_s = EXEC;
        end
      end
      ESPERA: begin
        if (eventoPress_r) begin
          proxEstado_s = LIBERA;
        end else begin
          proxEstado_s = ESPERA;
        end
      end
      LIBERA: begin
        habilita_s   = 1'b1;
        proxEstado_s = EXEC;
      end
      PARADO: begin
        proxEstado_s = PARADO;
      end
      default: begin
        proxEstado_s = EXEC;
      end
    endcase
  end

  assign canalValido_s = (int'(Canal) < NUM_CANAIS);
  assign escrita_s     = habilita_s & Out & ~Halt & canalValido_s;

  // Captured switches and registered state flags
  always_ff @(posedge Clock) begin
    if (Reset) begin
      dadoEntrada_r <= '0;
      esperando_r   <= 1'b0;
      parado_r      <= 1'b0;
    end else begin
      if ((estado_r == ESPERA) && eventoPress_r) begin
        dadoEntrada_r <= LARGURA_DADO'(Sw);
      end
      esperando_r <= (proxEstado_s == ESPERA);
      parado_r    <= (proxEstado_s == PARADO);
    end
  end

  // Output channel latches and per-channel update pulses
  always_ff @(posedge Clock) begin
    if (Reset) begin
      for (int k = 0; k < NUM_CANAIS; k++) begin
        canais_r[k] <= '0;
      end
      atualizado_r <= '0;
    end else begin
      atualizado_r <= '0;
      for (int k = 0; k < NUM_CANAIS; k++) begin
        if (escrita_s && (int'(Canal) == k)) begin
          canais_r[k]     <= DadoSaida;
          atualizado_r[k] <= 1'b1;
        end
      end
    end
  end

  for (genvar g = 0; g < NUM_CANAIS; g++) begin : gCanais
    assign SaidaCanais[g*LARGURA_DADO +: LARGURA_DADO] = canais_r[g];
  end

  assign DadoEntrada     = dadoEntrada_r;
  assign HabilitaCPU     = habilita_s;
  assign CanalAtualizado = atualizado_r;
  assign Esperando       = esperando_r;
  assign Parado          = parado_r;

endmodule

// File: tb/tb_controlador_entrada_saida.sv
// Directed bench for controlador_entrada_saida: channel model plus a capture
// scoreboard queue, checked with immediate assertions.
module tb_controlador_entrada_saida;

  logic        Clock = 1'b0;
  logic        Reset;
  logic [13:0] Sw;
  logic        Botao;
  logic        In;
  logic        Out;
  logic        Halt;
  logic [1:0]  Canal;
  logic [31:0] DadoSaida;
  logic [31:0] DadoEntrada;
  logic        HabilitaCPU;
  logic [95:0] SaidaCanais;
  logic [2:0]  CanalAtualizado;
  logic        Esperando;
  logic        Parado;

  int          checks   = 0;
  int          failures = 0;
  logic [31:0] chanExp [3];
  logic [31:0] capQ [$];
  logic [31:0] capEsp;

  controlador_entrada_saida #(
    .LARGURA_DADO(32),
    .LARGURA_SW(14),
    .NUM_CANAIS(3),
    .CICLOS_DEBOUNCE(4)
  ) dut (
    .Clock(Clock),
    .Reset(Reset),
    .Sw(Sw),
    .Botao(Botao),
    .In(In),
    .Out(Out),
    .Halt(Halt),
    .Canal(Canal),
    .DadoSaida(DadoSaida),
    .DadoEntrada(DadoEntrada),
    .HabilitaCPU(HabilitaCPU),
    .SaidaCanais(SaidaCanais),
    .CanalAtualizado(CanalAtualizado),
    .Esperando(Esperando),
    .Parado(Parado)
  );

  always #5 Clock = ~Clock;

  task automatic tick();
    @(posedge Clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [95:0] obs, input logic [95:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [95:0] canaisEsp();
    return {chanExp[2], chanExp[1], chanExp[0]};
  endfunction

  // Pops the next expected capture, counting an empty queue as a failure
  task automatic chkCaptura(input string tag);
    chk({tag, "_fila"}, 96'(capQ.size() != 0), 96'(1));
    if (capQ.size() != 0) begin
      capEsp = capQ.pop_front();
      chk(tag, 96'(DadoEntrada), 96'(capEsp));
    end
  endtask

  initial begin
    Reset = 1'b1; Sw = 14'h0; Botao = 1'b1; In = 1'b0; Out = 1'b0; Halt = 1'b0;
    Canal = 2'd0; DadoSaida = 32'h0;
    for (int k = 0; k < 3; k++) chanExp[k] = 32'h0;
    repeat (3) tick();
    Reset = 1'b0;
    #1;
    chk("rst_canais", SaidaCanais, canaisEsp());
    chk("rst_hab", 96'(HabilitaCPU), 96'(1));
    chk("rst_entrada", 96'(DadoEntrada), 96'(0));
    chk("rst_esperando", 96'(Esperando), 96'(0));
    chk("rst_parado", 96'(Parado), 96'(0));
    chk("rst_pulso", 96'(CanalAtualizado), 96'(0));

    // OUT to channel 2, then an out-of-range channel
    Out = 1'b1; Canal = 2'd2; DadoSaida = 32'h0000ABCD; chanExp[2] = 32'h0000ABCD;
    tick();
    Out = 1'b0;
    #1;
    chk("out_canais", SaidaCanais, canaisEsp());
    chk("out_pulso", 96'(CanalAtualizado), 96'(3'b100));
    tick();
    chk("out_pulso_fim", 96'(CanalAtualizado), 96'(0));
    Out = 1'b1; Canal = 2'd3; DadoSaida = 32'hFFFFFFFF;
    tick();
    Out = 1'b0;
    #1;
    chk("out_inval_canais", SaidaCanais, canaisEsp());
    chk("out_inval_pulso", 96'(CanalAtualizado), 96'(0));

    // IN handshake
    In = 1'b1; Sw = 14'h1A5;
    #1;
    chk("in_hab_exec", 96'(HabilitaCPU), 96'(0));
    tick();
    chk("in_espera", 96'(Esperando), 96'(1));
    repeat (9) begin
      tick();
      chk("in_espera_hold", 96'(Esperando), 96'(1));
      chk("in_espera_hab", 96'(HabilitaCPU), 96'(0));
    end
    Botao = 1'b0;
    capQ.push_back(32'h000001A5);
    for (int i = 1; i <= 6; i++) begin
      tick();
      chk("in_debounce_esp", 96'(Esperando), 96'(1));
      chk("in_debounce_hab", 96'(HabilitaCPU), 96'(0));
    end
    tick();
    chk("libera_hab", 96'(HabilitaCPU), 96'(1));
    chk("libera_esp", 96'(Esperando), 96'(0));
    chkCaptura("captura1");
    tick();
    chk("libera_um_ciclo", 96'(HabilitaCPU), 96'(0));
    chk("libera_exec_esp", 96'(Esperando), 96'(0));
    tick();
    chk("reespera", 96'(Esperando), 96'(1));
    Botao = 1'b1;
    repeat (8) tick();
    chk("soltura_sem_evento", 96'(Esperando), 96'(1));

    // Bounce: low/high every 2 cycles must never be accepted
    for (int i = 0; i < 10; i++) begin
      Botao = (i % 2 == 0) ? 1'b0 : 1'b1;
      tick();
      tick();
      chk("bounce_esp", 96'(Esperando), 96'(1));
      chk("bounce_hab", 96'(HabilitaCPU), 96'(0));
    end
    tick();
    Sw = 14'h2C3A; Botao = 1'b0;
    capQ.push_back(32'h00002C3A);
    repeat (5) begin
      tick();
      chk("press5_esp", 96'(Esperando), 96'(1));
    end
    Botao = 1'b1;
    tick();
    chk("press5_esp6", 96'(Esperando), 96'(1));
    tick();
    chk("press5_hab", 96'(HabilitaCPU), 96'(1));
    chkCaptura("captura2");
    In = 1'b0;
    tick();
    chk("pos_in_hab", 96'(HabilitaCPU), 96'(1));
    chk("pos_in_esp", 96'(Esperando), 96'(0));
    chk("captura_unica", 96'(capQ.size()), 96'(0));

    // Halt beats In and Out in the same cycle
    Halt = 1'b1; In = 1'b1; Out = 1'b1; Canal = 2'd0; DadoSaida = 32'hDEADBEEF;
    #1;
    chk("halt_hab_comb", 96'(HabilitaCPU), 96'(0));
    tick();
    Halt = 1'b0; In = 1'b0; Out = 1'b0;
    #1;
    chk("halt_parado", 96'(Parado), 96'(1));
    chk("halt_hab", 96'(HabilitaCPU), 96'(0));
    chk("halt_canais", SaidaCanais, canaisEsp());
    chk("halt_pulso", 96'(CanalAtualizado), 96'(0));
    Out = 1'b1; Canal = 2'd1; DadoSaida = 32'h55555555; Sw = 14'h3FFF; Botao = 1'b0;
    repeat (10) tick();
    Botao = 1'b1; Out = 1'b0;
    repeat (8) tick();
    chk("parado_preso", 96'(Parado), 96'(1));
    chk("parado_hab", 96'(HabilitaCPU), 96'(0));
    chk("parado_esp", 96'(Esperando), 96'(0));
    chk("parado_entrada", 96'(DadoEntrada), 96'(32'h00002C3A));
    chk("parado_canais", SaidaCanais, canaisEsp());

    Reset = 1'b1;
    tick();
    Reset = 1'b0;
    for (int k = 0; k < 3; k++) chanExp[k] = 32'h0;
    #1;
    chk("rst2_parado", 96'(Parado), 96'(0));
    chk("rst2_hab", 96'(HabilitaCPU), 96'(1));
    chk("rst2_entrada", 96'(DadoEntrada), 96'(0));
    chk("rst2_canais", SaidaCanais, canaisEsp());

    // Reset in ESPERA two cycles after the raw press
    In = 1'b1;
    tick();
    chk("mid_espera", 96'(Esperando), 96'(1));
    Sw = 14'h3FFF; Botao = 1'b0;
    tick();
    tick();
    Reset = 1'b1;
    tick();
    Reset = 1'b0; In = 1'b0;
    #1;
    chk("mid_rst_esp", 96'(Esperando), 96'(0));
    chk("mid_rst_hab", 96'(HabilitaCPU), 96'(1));
    chk("mid_rst_entrada", 96'(DadoEntrada), 96'(0));
    repeat (10) begin
      tick();
      chk("mid_sem_captura", 96'(DadoEntrada), 96'(0));
      chk("mid_sem_espera", 96'(Esperando), 96'(0));
    end
    Botao = 1'b1;
    repeat (8) tick();

    // Back-to-back OUT on channels 0 and 1
    Out = 1'b1; Canal = 2'd0; DadoSaida = 32'h12345678; chanExp[0] = 32'h12345678;
    tick();
    Canal = 2'd1; DadoSaida = 32'h9ABCDEF0;
    #1;
    chk("out0_pulso", 96'(CanalAtualizado), 96'(3'b001));
    chk("out0_canais", SaidaCanais, canaisEsp());
    chanExp[1] = 32'h9ABCDEF0;
    tick();
    Out = 1'b0;
    #1;
    chk("out1_pulso", 96'(CanalAtualizado), 96'(3'b010));
    chk("out1_canais", SaidaCanais, canaisEsp());

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
